// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests and
// a 2-entry prefetch FIFO feeding the IF/ID register.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic        dbg_drain_o
);

   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam logic [2:0]  DEPTH_W  = 3'(FIFO_DEPTH);

   typedef enum logic {ST_RUN, ST_DRAIN} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  os_cnt_q, os_cnt_d;
   logic [1:0]  disc_cnt_q, disc_cnt_d;
   logic [1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [31:0] aq_q [2];
   logic [31:0] aq_d [2];
   logic [31:0] fa_q [2];
   logic [31:0] fa_d [2];
   logic [31:0] fi_q [2];
   logic [31:0] fi_d [2];

   logic        credit_ok, gnt, rsp, pop;
   logic [1:0]  aq_wr_idx, fifo_wr_idx;
   logic        unused_jump_lsb;

   assign unused_jump_lsb = ^jump_addr_i[1:0];

   // Handshake: a request is taken on an edge where mem_req_o & mem_gnt_i;
   // mem_rvalid_i returns one word per granted request, in grant order.
   assign credit_ok    = ({1'b0, os_cnt_q} + {1'b0, fifo_cnt_q}) < DEPTH_W;
   assign mem_req_o    = (state_q == ST_RUN) & ~jump_en_i & credit_ok;
   assign mem_addr_o   = pc_q;
   assign gnt          = mem_req_o & mem_gnt_i;
   assign rsp          = mem_rvalid_i & (os_cnt_q != 2'd0);
   assign inst_valid_o = (fifo_cnt_q != 2'd0);
   assign pop          = inst_valid_o & ~hold_flag_i & ~jump_en_i;
   assign inst_o       = inst_valid_o ? fi_q[0] : INST_NOP;
   assign inst_addr_o  = inst_valid_o ? fa_q[0] : 32'h0;
   assign dbg_drain_o  = (state_q == ST_DRAIN);
   assign aq_wr_idx    = os_cnt_q - {1'b0, rsp};
   assign fifo_wr_idx  = fifo_cnt_q - {1'b0, pop};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      os_cnt_d   = os_cnt_q;
      disc_cnt_d = disc_cnt_q;
      fifo_cnt_d = fifo_cnt_q;
      aq_d       = aq_q;
      fa_d       = fa_q;
      fi_d       = fi_q;
      if (jump_en_i) begin
         // Address-queue contents go stale here; the count returns to zero
         // before RUN resumes, so the entries need no clearing.
         pc_d       = {jump_addr_i[31:2], 2'b00};
         fifo_cnt_d = 2'd0;
         os_cnt_d   = os_cnt_q - {1'b0, rsp};
         disc_cnt_d = os_cnt_q - {1'b0, rsp};
         state_d    = (os_cnt_q - {1'b0, rsp} != 2'd0) ? ST_DRAIN : ST_RUN;
      end else if (state_q == ST_DRAIN) begin
         if (rsp) begin
            os_cnt_d   = os_cnt_q - 2'd1;
            disc_cnt_d = disc_cnt_q - 2'd1;
            if (disc_cnt_q == 2'd1) state_d = ST_RUN;
         end
      end else begin
         if (gnt) pc_d = pc_q + 32'd4;
         os_cnt_d = os_cnt_q + {1'b0, gnt} - {1'b0, rsp};
         if (rsp) aq_d[0] = aq_q[1];
         if (gnt) aq_d[aq_wr_idx[0]] = pc_q;
         if (pop) begin
            fa_d[0] = fa_q[1];
            fi_d[0] = fi_q[1];
         end
         if (rsp) begin
            fa_d[fifo_wr_idx[0]] = aq_q[0];
            fi_d[fifo_wr_idx[0]] = mem_rdata_i;
         end
         fifo_cnt_d = fifo_cnt_q + {1'b0, rsp} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         os_cnt_q   <= 2'd0;
         disc_cnt_q <= 2'd0;
         fifo_cnt_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            aq_q[i] <= 32'h0;
            fa_q[i] <= 32'h0;
            fi_q[i] <= 32'h0;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         os_cnt_q   <= os_cnt_d;
         disc_cnt_q <= disc_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         aq_q       <= aq_d;
         fa_q       <= fa_d;
         fi_q       <= fi_d;
      end
   end

endmodule
